// File: rtl/chunked_adder_pkg.sv
// chunked_adder_pkg: FSM state type and sizing helpers shared by the chunked adder.
package chunked_adder_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    function automatic int nchunk(input int w, input int c);
        return w / c;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunked_adder_chunk.sv
// chunk_add: W-bit ripple adder built from half-adder pairs; also exposes the carry into the MSB.
module chunk_add #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_ci,
    output logic [W-1:0] o_s,
    output logic         o_co,
    output logic         o_cm
);

    logic [W:0] w_c;

    assign w_c[0] = i_ci;

    for (genvar i = 0; i < W; i++) begin : g_bit
        logic w_p, w_g;
        assign w_p        = i_a[i] ^ i_b[i];
        assign w_g        = i_a[i] & i_b[i];
        assign o_s[i]     = w_p ^ w_c[i];
        assign w_c[i + 1] = w_g | (w_p & w_c[i]);
    end

    assign o_co = w_c[W];
    assign o_cm = w_c[W - 1];

endmodule

// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle add/subtract, CHUNK bits per clock through a registered carry,
// with valid/ready handshakes on operands and result.
module chunked_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    import chunked_adder_pkg::*;

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int CW     = cnt_w(NCHUNK);

    if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("chunked_adder: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_sum;
    logic             r_c, r_cout, r_ovf;
    logic [CW-1:0]    r_cnt;
    logic [CHUNK-1:0] w_ac, w_bc, w_s;
    logic             w_co, w_cm, w_last;

    assign w_last = (r_cnt == CW'(NCHUNK - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                w_next   = in_valid ? CALC : IDLE;
            end
            CALC:    w_next = w_last ? DONE : CALC;
            DONE: begin
                out_valid = 1'b1;
                w_next    = out_ready ? IDLE : DONE;
            end
            default: w_next = IDLE;
        endcase
    end

    // One shared chunk adder; the counter selects which slice feeds it.
    always_comb begin
        w_ac = '0;
        w_bc = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (r_cnt == CW'(k)) begin
                w_ac = r_a[k*CHUNK +: CHUNK];
                w_bc = r_b[k*CHUNK +: CHUNK];
            end
        end
    end

    chunk_add #(.W(CHUNK)) u_chunk (
        .i_a  (w_ac),
        .i_b  (w_bc),
        .i_ci (r_c),
        .o_s  (w_s),
        .o_co (w_co),
        .o_cm (w_cm)
    );

    // Subtraction is A + ~B + 1, so only the inverted operand and forced carry are stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_c    <= 1'b0;
            r_cnt  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (r_state == IDLE && in_valid) begin
            r_a   <= a;
            r_b   <= sub ? ~b : b;
            r_c   <= sub | cin;
            r_cnt <= '0;
        end else if (r_state == CALC) begin
            for (int k = 0; k < NCHUNK; k++) begin
                if (r_cnt == CW'(k)) r_sum[k*CHUNK +: CHUNK] <= w_s;
            end
            r_c   <= w_co;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_cout <= w_co;
                r_ovf  <= w_co ^ w_cm;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_chunked_adder.sv
// tb_chunked_adder: directed vectors on the 16/4 adder plus a reference sweep over four shapes.
module tb_chunked_adder;

    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, cin = 1'b0, sub = 1'b0, out_ready = 1'b0;
    logic [15:0] a = '0, b = '0;

    logic        rdy16, v16, co16, ov16;
    logic [15:0] s16;
    logic        rdy8a, v8a, co8a, ov8a;
    logic [7:0]  s8a;
    logic        rdy8b, v8b, co8b, ov8b;
    logic [7:0]  s8b;
    logic        rdy12, v12, co12, ov12;
    logic [11:0] s12;

    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    chunked_adder #(.WIDTH(16), .CHUNK(4)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(v16), .out_ready(out_ready), .sum(s16), .cout(co16), .ovf(ov16)
    );
    chunked_adder #(.WIDTH(8), .CHUNK(1)) u8a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8a), .a(a[7:0]), .b(b[7:0]),
        .cin(cin), .sub(sub), .out_valid(v8a), .out_ready(out_ready), .sum(s8a), .cout(co8a), .ovf(ov8a)
    );
    chunked_adder #(.WIDTH(8), .CHUNK(8)) u8b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8b), .a(a[7:0]), .b(b[7:0]),
        .cin(cin), .sub(sub), .out_valid(v8b), .out_ready(out_ready), .sum(s8b), .cout(co8b), .ovf(ov8b)
    );
    chunked_adder #(.WIDTH(12), .CHUNK(3)) u12 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy12), .a(a[11:0]), .b(b[11:0]),
        .cin(cin), .sub(sub), .out_valid(v12), .out_ready(out_ready), .sum(s12), .cout(co12), .ovf(ov12)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} of a w-bit add/subtract.
    function automatic logic [17:0] ref_f(input int w, input logic [15:0] x, input logic [15:0] y,
                                          input logic c, input logic s);
        logic [16:0] m, xx, yy, t;
        logic [15:0] r;
        m  = (17'd1 << w) - 17'd1;
        xx = {1'b0, x} & m;
        yy = {1'b0, s ? ~y : y} & m;
        t  = xx + yy + {16'd0, s | c};
        r  = t[15:0] & m[15:0];
        return {(xx[w-1] == yy[w-1]) && (r[w-1] != xx[w-1]), t[w], r};
    endfunction

    task automatic launch_wait(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                               input logic ts, output int lat);
        int n;
        lat = -1;
        @(negedge clk);
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (n = 0; n < 40; n++) begin
            if (v16 && lat < 0) lat = n;
            if (v16 && v8a && v8b && v12) break;
            @(negedge clk);
        end
        if (n == 40) chk("timeout", 32'd0, 32'd1);
    endtask

    task automatic release_out();
        @(negedge clk) out_ready = 1'b1;
        @(negedge clk) out_ready = 1'b0;
    endtask

    task automatic check_all(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input logic ts);
        logic [17:0] e;
        e = ref_f(16, ta, tb, tc, ts);
        chk("ref16x4", {14'd0, ov16, co16, s16}, {14'd0, e});
        e = ref_f(8, ta, tb, tc, ts);
        chk("ref8x1", {22'd0, ov8a, co8a, s8a}, {22'd0, e[17:16], e[7:0]});
        chk("ref8x8", {22'd0, ov8b, co8b, s8b}, {22'd0, e[17:16], e[7:0]});
        e = ref_f(12, ta, tb, tc, ts);
        chk("ref12x3", {18'd0, ov12, co12, s12}, {18'd0, e[17:16], e[11:0]});
    endtask

    task automatic dir(input string tag, input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                       input logic ts, input logic [15:0] es, input logic ec, input logic eo);
        int lat;
        launch_wait(ta, tb, tc, ts, lat);
        chk({tag, "_lat"}, lat, 32'd4);
        chk({tag, "_sum"}, {16'd0, s16}, {16'd0, es});
        chk({tag, "_cout"}, {31'd0, co16}, {31'd0, ec});
        chk({tag, "_ovf"}, {31'd0, ov16}, {31'd0, eo});
        check_all(ta, tb, tc, ts);
        release_out();
    endtask

    initial begin
        int lat, t1, t2;
        logic [15:0] ra, rb;
        logic rc, rs;

        repeat (3) @(negedge clk);
        chk("rst_rdy", {31'd0, rdy16}, 32'd1);
        chk("rst_vld", {31'd0, v16}, 32'd0);
        chk("rst_sum", {16'd0, s16}, 32'd0);
        chk("rst_cout", {31'd0, co16}, 32'd0);
        chk("rst_ovf", {31'd0, ov16}, 32'd0);
        rst_n = 1'b1;

        dir("add",    16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        dir("carry",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        dir("ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        dir("sub",    16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        dir("subovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        dir("cin",    16'h1000, 16'h2000, 1'b1, 1'b0, 16'h3001, 1'b0, 1'b0);

        launch_wait(16'h1234, 16'h1111, 1'b0, 1'b0, lat);
        a = 16'hAAAA; b = 16'h5555; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_sum", {16'd0, s16}, 32'h2345);
            chk("bp_rdy", {31'd0, rdy16}, 32'd0);
            chk("bp_vld", {31'd0, v16}, 32'd1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk) out_ready = 1'b0;
        chk("bp_idle", {31'd0, rdy16}, 32'd1);
        chk("bp_done", {31'd0, v16}, 32'd0);
        repeat (6) @(negedge clk);
        chk("bp_noacc", {31'd0, v16}, 32'd0);

        a = 16'h0102; b = 16'h0304; cin = 1'b1; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        t1 = -1; t2 = -1;
        for (int n = 0; n < 40 && t2 < 0; n++) begin
            @(negedge clk);
            if (v16) begin
                chk("ii_sum", {16'd0, s16}, 32'h0407);
                if (t1 < 0) t1 = n;
                else t2 = n;
            end
        end
        chk("ii_gap", t2 - t1, 32'd6);
        in_valid = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk) in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mr_rdy", {31'd0, rdy16}, 32'd1);
        chk("mr_vld", {31'd0, v16}, 32'd0);
        chk("mr_sum", {16'd0, s16}, 32'd0);
        chk("mr_cout", {31'd0, co16}, 32'd0);
        chk("mr_ovf", {31'd0, ov16}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        dir("post_rst", 16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

        for (int i = 0; i < 10; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
            launch_wait(ra, rb, rc, rs, lat);
            check_all(ra, rb, rc, rs);
            release_out();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
